// File: rtl/sample_averager.sv
// Moving-average filter over a power-of-two window of unsigned ADC samples.
// Keeps a circular sample buffer and a running sum so each accept costs one add/subtract.
module sample_averager #(
   parameter int DATA_W    = 16,
   parameter int TAPS_LOG2 = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [DATA_W-1:0]    in_data,
   output logic                 in_ready,
   input  logic                 flush,
   output logic                 out_valid,
   output logic [DATA_W-1:0]    out_data,
   input  logic                 out_ready,
   output logic [TAPS_LOG2:0]   fill_count,
   output logic                 o_dbg_state
);

   localparam int TAPS  = 1 << TAPS_LOG2;
   localparam int SUM_W = DATA_W + TAPS_LOG2;
   localparam logic [TAPS_LOG2:0]   FILL_FULL = (TAPS_LOG2+1)'(TAPS);
   localparam logic [TAPS_LOG2:0]   FILL_LAST = (TAPS_LOG2+1)'(TAPS - 1);
   localparam logic [TAPS_LOG2:0]   FILL_ONE  = (TAPS_LOG2+1)'(1);
   localparam logic [TAPS_LOG2-1:0] PTR_ONE   = TAPS_LOG2'(1);

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [DATA_W-1:0]     r_buf [TAPS];
   logic [TAPS_LOG2-1:0]  r_wr_ptr;
   logic [SUM_W-1:0]      r_sum;
   logic [TAPS_LOG2:0]    r_fill;
   logic                  r_out_valid;
   logic [DATA_W-1:0]     r_out_data;

   logic                  w_accept;
   logic                  w_produce;
   logic [DATA_W-1:0]     w_old;
   logic [SUM_W-1:0]      w_new_sum;
   logic [DATA_W-1:0]     w_avg;

   // Handshake: a sample transfers on a rising edge where in_valid && in_ready && !flush;
   // a result transfers where out_valid && out_ready. in_ready is combinational so a
   // consumed result frees the output slot for a new sample in the same cycle.
   assign in_ready  = !r_out_valid || out_ready;
   assign w_accept  = in_valid && in_ready && !flush;
   assign w_produce = w_accept && ((r_state == ST_RUN) || (r_fill == FILL_LAST));

   // Displaced entry is zero while filling because the buffer is cleared on reset/flush.
   assign w_old     = r_buf[r_wr_ptr];
   assign w_new_sum = r_sum + {{TAPS_LOG2{1'b0}}, in_data} - {{TAPS_LOG2{1'b0}}, w_old};
   assign w_avg     = w_new_sum[SUM_W-1:TAPS_LOG2];

   assign out_valid   = r_out_valid;
   assign out_data    = r_out_data;
   assign fill_count  = r_fill;
   assign o_dbg_state = r_state;

   always_comb begin
      w_next_state = r_state;
      if (flush) begin
         w_next_state = ST_FILL;
      end else if (w_accept && (r_state == ST_FILL) && (r_fill == FILL_LAST)) begin
         w_next_state = ST_RUN;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_FILL;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < TAPS; i++) r_buf[i] <= '0;
         r_wr_ptr <= '0;
         r_sum    <= '0;
         r_fill   <= '0;
      end else if (flush) begin
         for (int i = 0; i < TAPS; i++) r_buf[i] <= '0;
         r_wr_ptr <= '0;
         r_sum    <= '0;
         r_fill   <= '0;
      end else if (w_accept) begin
         r_buf[r_wr_ptr] <= in_data;
         r_wr_ptr        <= r_wr_ptr + PTR_ONE;
         r_sum           <= w_new_sum;
         if (r_fill != FILL_FULL) r_fill <= r_fill + FILL_ONE;
      end
   end

   // A fresh result always wins over retiring the old one, giving one result per clock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end else if (w_produce) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_avg;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sample_averager.sv
// Bench for sample_averager: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a queue-based window model.
module tb_sample_averager;

  localparam int DW   = 16;
  localparam int TL   = 2;
  localparam int TAPS = 1 << TL;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          flush;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [TL:0]   fill_count;
  logic          o_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: window of accepted samples plus the pending result
  int            window[$];
  bit            m_valid;
  logic [DW-1:0] m_data;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          f;
    logic          r;
    logic          ev;
    logic [DW-1:0] ed;
    logic [TL:0]   ef;
  } vec_t;
  vec_t tbl[$];

  sample_averager #(.DATA_W(DW), .TAPS_LOG2(TL)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .fill_count  (fill_count),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    window.delete(); m_valid = 0; m_data = '0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_fill", {29'd0, fill_count}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    check("rst_out_data", {16'd0, out_data}, 0);
    reset = 1'b1;
  endtask

  function automatic void add(input logic v, input logic [DW-1:0] d, input logic f,
                              input logic r, input logic ev, input logic [DW-1:0] ed,
                              input logic [TL:0] ef);
    vec_t e;
    e.v = v; e.d = d; e.f = f; e.r = r; e.ev = ev; e.ed = ed; e.ef = ef;
    tbl.push_back(e);
  endfunction

  // driver: one clock of stimulus, in_ready checked before the edge, model advanced at it
  task automatic apply(input logic v, input logic [DW-1:0] d, input logic f, input logic r);
    bit rdy;
    int s;
    in_valid = v; in_data = d; flush = f; out_ready = r;
    rdy = !m_valid || r;
    #1;
    check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    @(posedge clk);
    if (f) begin
      window.delete();
      m_valid = 0;
    end else if (v && rdy) begin
      window.push_back(int'(d));
      if (window.size() > TAPS) void'(window.pop_front());
      if (window.size() == TAPS) begin
        s = 0;
        foreach (window[i]) s += window[i];
        m_valid = 1;
        m_data  = DW'(s / TAPS);
      end else if (r) begin
        m_valid = 0;
      end
    end else if (r) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic check_model();
    check("m_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid) check("m_out_data", {16'd0, out_data}, {16'd0, m_data});
    check("m_fill", {29'd0, fill_count}, window.size());
    check("m_state", {31'd0, o_dbg_state}, {31'd0, window.size() == TAPS});
  endtask

  initial begin
    do_reset();

    // fill/slide, flush with valid, full scale, truncation, back-to-back
    add(1, 100, 0, 1, 0, 0, 1);
    add(1, 200, 0, 1, 0, 0, 2);
    add(1, 300, 0, 1, 0, 0, 3);
    add(1, 400, 0, 1, 1, 250, 4);
    add(1, 500, 0, 1, 1, 350, 4);
    add(0, 0,   0, 1, 0, 0, 4);
    add(1, 7,   1, 1, 0, 0, 0);
    add(1, 16'hFFFF, 0, 1, 0, 0, 1);
    add(1, 16'hFFFF, 0, 1, 0, 0, 2);
    add(1, 16'hFFFF, 0, 1, 0, 0, 3);
    add(1, 16'hFFFF, 0, 1, 1, 16'hFFFF, 4);
    add(0, 0,   1, 1, 0, 0, 0);
    add(1, 1,   0, 1, 0, 0, 1);
    add(1, 1,   0, 1, 0, 0, 2);
    add(1, 1,   0, 1, 0, 0, 3);
    add(1, 2,   0, 1, 1, 1, 4);
    add(1, 9,   0, 1, 1, 3, 4);
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].r);
      check($sformatf("tbl%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ev});
      if (tbl[i].ev) check($sformatf("tbl%0d_data", i), {16'd0, out_data}, {16'd0, tbl[i].ed});
      check($sformatf("tbl%0d_fill", i), {29'd0, fill_count}, {29'd0, tbl[i].ef});
    end

    // backpressure: result pending with out_ready low stalls the input
    do_reset();
    apply(1, 10, 0, 0); apply(1, 20, 0, 0); apply(1, 30, 0, 0); apply(1, 40, 0, 0);
    check("bp_valid", {31'd0, out_valid}, 1);
    check("bp_data", {16'd0, out_data}, 25);
    for (int k = 0; k < 5; k++) begin
      apply(1, 50, 0, 0);
      check("bp_in_ready", {31'd0, in_ready}, 0);
      check("bp_hold_data", {16'd0, out_data}, 25);
      check("bp_hold_fill", {29'd0, fill_count}, 4);
      check("bp_hold_valid", {31'd0, out_valid}, 1);
    end
    apply(1, 50, 0, 1);
    check("bp_release_data", {16'd0, out_data}, 35);
    check("bp_release_valid", {31'd0, out_valid}, 1);
    apply(0, 0, 0, 1);
    check("bp_drain_valid", {31'd0, out_valid}, 0);

    // flush mid-fill: sample in the flush cycle is dropped
    do_reset();
    apply(1, 4, 0, 1); apply(1, 4, 0, 1);
    apply(1, 99, 1, 1);
    check("fl_fill", {29'd0, fill_count}, 0);
    for (int k = 0; k < 3; k++) begin
      apply(1, 12, 0, 1);
      check("fl_no_valid", {31'd0, out_valid}, 0);
    end
    apply(1, 12, 0, 1);
    check("fl_valid", {31'd0, out_valid}, 1);
    check("fl_data", {16'd0, out_data}, 12);

    // asynchronous reset mid-RUN with a held result
    apply(1, 1000, 0, 0);
    check("ar_pre_valid", {31'd0, out_valid}, 1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_async_valid", {31'd0, out_valid}, 0);
    check("ar_async_ready", {31'd0, in_ready}, 1);
    check("ar_async_fill", {29'd0, fill_count}, 0);
    window.delete(); m_valid = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      apply(1, 8, 0, 1);
      check("ar_no_valid", {31'd0, out_valid}, 0);
    end
    apply(1, 8, 0, 1);
    check("ar_valid", {31'd0, out_valid}, 1);
    check("ar_data", {16'd0, out_data}, 8);

    // randomized traffic against the model
    do_reset();
    for (int k = 0; k < 600; k++) begin
      apply($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 31) == 0,
            $urandom_range(0, 2) != 0);
      check_model();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
